// File: rtl/lsu_issue_arbiter.sv
// lsu_issue_arbiter: round-robin issue of two LSU requesters into the
// bypass buffer, with a shadow class queue that steers the buffer head.
//
// Ports:
//   clk_i, rst_i        clock, async active-high reset
//   flush_i             synchronous clear of tracking state
//   req_valid_i/req_i/  two requesters: valid, request word, store class
//   req_is_st_i
//   req_ready_o         one-hot grant, consumed this cycle
//   lsu_req_o/_valid_o  granted request and push strobe to the bypass
//   ld_/st_valid_o      head offered to load or store unit
//   ld_/st_ready_i      unit accepts
//   pop_ld_o/pop_st_o   pop strobes to the bypass
//   busy_o              buffer holds at least one entry
module lsu_issue_arbiter #(
  parameter int REQ_W = 85,
  parameter int DEPTH = 2
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               flush_i,
  input  logic [1:0]         req_valid_i,
  input  logic [2*REQ_W-1:0] req_i,
  input  logic [1:0]         req_is_st_i,
  output logic [1:0]         req_ready_o,
  output logic [REQ_W-1:0]   lsu_req_o,
  output logic               lsu_req_valid_o,
  output logic               ld_valid_o,
  output logic               st_valid_o,
  input  logic               ld_ready_i,
  input  logic               st_ready_i,
  output logic               pop_ld_o,
  output logic               pop_st_o,
  output logic               busy_o
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  logic [CW-1:0]    cnt;
  logic [DEPTH-1:0] cls_q;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             rr_q;

  logic             head_st;
  logic             nonempty;
  logic             pop;
  logic             push;
  logic             space;
  logic             sel;
  logic [1:0]       gnt;

  assign head_st  = cls_q[rd_ptr];
  assign nonempty = (cnt != '0);

  assign ld_valid_o = nonempty & ~head_st & ~flush_i;
  assign st_valid_o = nonempty & head_st & ~flush_i;
  assign pop_ld_o   = ld_valid_o & ld_ready_i;
  assign pop_st_o   = st_valid_o & st_ready_i;
  assign pop        = pop_ld_o | pop_st_o;
  assign busy_o     = nonempty;

  // A pop in the same cycle frees the slot the push needs.
  assign space = (cnt < FULL) | pop;

  // Grant is gated by rst_i so the outputs fall with the reset edge
  // rather than waiting for the state to be cleared.
  always_comb begin
    gnt = 2'b00;
    if (!rst_i && !flush_i && space) begin
      if (&req_valid_i) begin
        gnt = rr_q ? 2'b10 : 2'b01;
      end else begin
        gnt = req_valid_i;
      end
    end
  end

  assign push            = |gnt;
  assign sel             = push ? gnt[1] : rr_q;
  assign req_ready_o     = gnt;
  assign lsu_req_valid_o = push;
  assign lsu_req_o       = sel ? req_i[REQ_W +: REQ_W]
                               : req_i[0 +: REQ_W];

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt    <= '0;
      cls_q  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      rr_q   <= 1'b0;
    end else if (flush_i) begin
      cnt    <= '0;
      cls_q  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        cls_q[wr_ptr] <= req_is_st_i[sel];
        wr_ptr        <= inc(wr_ptr);
        rr_q          <= ~sel;
      end
      if (pop) begin
        rd_ptr <= inc(rd_ptr);
      end
      cnt <= cnt + CW'(push) - CW'(pop);
    end
  end

endmodule
